// File: rtl/gpu_draw_pkg.sv
// ---------------------------------------------------------------------------
// gpu_draw_pkg
// Shared constants for the drawing-engine coordinate path:
//   - well-known channel indices of the drawing engines
//   - arbitration mode encodings for the MODE input
//   - arbiter FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package gpu_draw_pkg;

  // Drawing-engine channel indices
  localparam int CF      = 0;
  localparam int CD      = 1;
  localparam int RF      = 2;
  localparam int RD      = 3;
  localparam int LD      = 4;
  localparam int FU      = 10;
  localparam int IDLE_CH = 15;

  // Arbitration modes
  localparam logic SELECT = 1'b0;
  localparam logic RROBIN = 1'b1;

  // Arbiter FSM states
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage : gpu_draw_pkg

// File: rtl/draw_coord_arbiter_if.sv
// ---------------------------------------------------------------------------
// draw_coord_arbiter_if
// Bundles the per-channel coordinate inputs, the arbitration controls and the
// registered output beat of the coordinate arbiter.
//   master : environment side (engines + pixel writer) - drives mode, sel,
//            in_x/in_y/in_valid/in_last, out_ready
//   slave  : arbiter side - drives in_ready, out_x/out_y/out_valid/out_last,
//            out_ch, busy
// Channel i occupies in_x[i*XW +: XW] and in_y[i*YW +: YW].
// ---------------------------------------------------------------------------
interface draw_coord_arbiter_if #(
  parameter int NCH = 8,
  parameter int XW  = 9,
  parameter int YW  = 8,
  parameter int SW  = $clog2(NCH)
);

  logic              mode;
  logic [SW-1:0]     sel;
  logic [NCH*XW-1:0] in_x;
  logic [NCH*YW-1:0] in_y;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_last;
  logic [NCH-1:0]    in_ready;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic              out_valid;
  logic              out_last;
  logic [SW-1:0]     out_ch;
  logic              out_ready;
  logic              busy;

  modport master (
    output mode, sel, in_x, in_y, in_valid, in_last, out_ready,
    input  in_ready, out_x, out_y, out_valid, out_last, out_ch, busy
  );

  modport slave (
    input  mode, sel, in_x, in_y, in_valid, in_last, out_ready,
    output in_ready, out_x, out_y, out_valid, out_last, out_ch, busy
  );

endinterface : draw_coord_arbiter_if

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the lowest-numbered requesting
// channel strictly after last_i, wrapping NCH-1 -> 0. last_i itself is the
// final candidate, so a lone requester is always found.
//   req_i   : per-channel request vector
//   last_i  : index granted most recently
//   found_o : some channel requests
//   idx_o   : chosen channel (0 when found_o is low)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NCH = 8,
  parameter int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [SW-1:0]  last_i,
  output logic           found_o,
  output logic [SW-1:0]  idx_o
);

  always_comb begin
    int            c;
    logic [SW-1:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    cand    = '0;
    for (int k = 1; k <= NCH; k++) begin
      // Wrap with a compare/subtract instead of a modulo
      c = int'(last_i) + k;
      if (c >= NCH) c = c - NCH;
      cand = SW'(c);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/draw_coord_arbiter.sv
// ---------------------------------------------------------------------------
// draw_coord_arbiter
// Arbitrates NCH drawing-engine coordinate streams onto one registered
// coordinate beat for the pixel writer. A channel is locked for a whole
// primitive (until its last beat is accepted); arbitration happens only in
// IDLE, either by explicit select (SEL) or round-robin.
// Ports:
//   CLK   : clock, all state on the rising edge
//   RST_N : asynchronous active-low reset
//   bus   : draw_coord_arbiter_if.slave (controls, channel inputs, output beat)
// ---------------------------------------------------------------------------
module draw_coord_arbiter
  import gpu_draw_pkg::*;
#(
  parameter int NCH = 8,
  parameter int XW  = 9,
  parameter int YW  = 8,
  parameter int SW  = $clog2(NCH)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  draw_coord_arbiter_if.slave   bus
);

  // SEL extended by one bit so NCH itself is representable in the compare
  localparam logic [SW:0] NCH_EXT = (SW+1)'(NCH);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] gnt_q, gnt_d;
  logic [SW-1:0] last_q, last_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [YW-1:0] out_y_q, out_y_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [SW-1:0] out_ch_q, out_ch_d;

  logic [XW-1:0]  x_arr [NCH];
  logic [YW-1:0]  y_arr [NCH];
  logic           rr_found;
  logic [SW-1:0]  rr_idx;
  logic           sel_ok;
  logic           can_accept;
  logic           accept;
  logic [NCH-1:0] in_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign x_arr[i] = bus.in_x[i*XW +: XW];
    assign y_arr[i] = bus.in_y[i*YW +: YW];
  end

  rr_pick #(
    .NCH (NCH),
    .SW  (SW)
  ) u_rr_pick (
    .req_i   (bus.in_valid),
    .last_i  (last_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  // Out-of-range SEL never grants; the index is only evaluated when in range
  assign sel_ok     = ({1'b0, bus.sel} < NCH_EXT) && bus.in_valid[bus.sel];
  // Output register can take a new beat when empty or draining this cycle
  assign can_accept = ~out_valid_q | bus.out_ready;

  always_comb begin
    in_ready = '0;
    if (state_q == LOCK && can_accept) in_ready[gnt_q] = 1'b1;
  end

  assign accept = in_ready[gnt_q] & bus.in_valid[gnt_q];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    case (state_q)
      IDLE: begin
        if (bus.mode == RROBIN) begin
          if (rr_found) begin
            state_d = LOCK;
            gnt_d   = rr_idx;
          end
        end else if (sel_ok) begin
          state_d = LOCK;
          gnt_d   = bus.sel;
        end
      end
      LOCK: begin
        // Release on the same edge the last beat is taken
        if (accept && bus.in_last[gnt_q]) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_x_d     = x_arr[gnt_q];
      out_y_d     = y_arr[gnt_q];
      out_last_d  = bus.in_last[gnt_q];
      out_ch_d    = gnt_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      gnt_q       <= SW'(CF);
      last_q      <= SW'(NCH-1);
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = (state_q == LOCK);

endmodule : draw_coord_arbiter

// File: tb/tb_draw_coord_arbiter.sv
// ---------------------------------------------------------------------------
// tb_draw_coord_arbiter
// Scoreboard bench for draw_coord_arbiter: per-channel beats wait in a
// pending queue and are presented on their channel; expected output beats are
// queued in grant order and compared as the DUT hands them downstream.
// A second instance with NCH=6 covers an out-of-range SEL.
// ---------------------------------------------------------------------------
module tb_draw_coord_arbiter;
  import gpu_draw_pkg::*;

  localparam int NCH = 8;
  localparam int XW  = 9;
  localparam int YW  = 8;
  localparam int SW  = 3;

  typedef struct packed {
    logic [3:0]    ch;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
  } beat_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  draw_coord_arbiter_if #(.NCH(NCH), .XW(XW), .YW(YW), .SW(SW)) bus ();
  draw_coord_arbiter #(.NCH(NCH), .XW(XW), .YW(YW), .SW(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  draw_coord_arbiter_if #(.NCH(6), .XW(XW), .YW(YW), .SW(3)) bus6 ();
  draw_coord_arbiter #(.NCH(6), .XW(XW), .YW(YW), .SW(3)) dut6 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus6)
  );

  beat_t pend[$];
  beat_t exp_q[$];
  int    obs_cyc[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  function automatic beat_t mk(input int ch, input int x, input int y, input bit last);
    beat_t b;
    b.ch   = 4'(ch);
    b.x    = XW'(x);
    b.y    = YW'(y);
    b.last = last;
    return b;
  endfunction

  task automatic push_both(input int ch, input int x, input int y, input bit last);
    pend.push_back(mk(ch, x, y, last));
    exp_q.push_back(mk(ch, x, y, last));
  endtask

  function automatic int n_pend(input int ch);
    int n = 0;
    foreach (pend[j]) if (int'(pend[j].ch) == ch) n++;
    return n;
  endfunction

  // Present the oldest pending beat of every channel
  task automatic drive_inputs();
    logic [NCH-1:0]    v, l;
    logic [NCH*XW-1:0] xs;
    logic [NCH*YW-1:0] ys;
    v = '0; l = '0; xs = '0; ys = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < pend.size(); j++) begin
        if (int'(pend[j].ch) == i) begin
          v[i]            = 1'b1;
          l[i]            = pend[j].last;
          xs[i*XW +: XW]  = pend[j].x;
          ys[i*YW +: YW]  = pend[j].y;
          break;
        end
      end
    end
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_x     = xs;
    bus.in_y     = ys;
  endtask

  // One clock: compare any beat leaving the DUT, then retire accepted inputs
  task automatic tick();
    logic [NCH-1:0] acc;
    beat_t          e;
    @(negedge CLK);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("beat{ch,x,y,last}", {10'd0, 1'b0, bus.out_ch, bus.out_x, bus.out_y, bus.out_last},
            {10'd0, e});
        obs_cyc.push_back(cyc);
      end
    end
    acc = bus.in_valid & bus.in_ready;
    @(posedge CLK);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) begin
        for (int j = 0; j < pend.size(); j++) begin
          if (int'(pend[j].ch) == i) begin
            pend.delete(j);
            break;
          end
        end
      end
    end
    drive_inputs();
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    c0;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;

    bus.mode = SELECT; bus.sel = '0; bus.out_ready = 1'b1;
    bus.in_valid = '0; bus.in_last = '0; bus.in_x = '0; bus.in_y = '0;
    bus6.mode = SELECT; bus6.sel = '0; bus6.out_ready = 1'b1;
    bus6.in_valid = '0; bus6.in_last = '0; bus6.in_x = '0; bus6.in_y = '0;

    // Reset values before any clock edge
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_data", {bus.out_x, bus.out_y, bus.out_ch, bus.out_last}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Round-robin from reset: 1,3,6,1 with one bubble between primitives
    bus.mode = RROBIN;
    pend.push_back(mk(1, 10, 20, 0)); pend.push_back(mk(1, 11, 20, 1));
    pend.push_back(mk(1, 12, 21, 0)); pend.push_back(mk(1, 13, 21, 1));
    pend.push_back(mk(3, 30, 33, 0)); pend.push_back(mk(3, 31, 33, 1));
    pend.push_back(mk(6, 60, 66, 0)); pend.push_back(mk(6, 61, 66, 1));
    exp_q.push_back(mk(1, 10, 20, 0)); exp_q.push_back(mk(1, 11, 20, 1));
    exp_q.push_back(mk(3, 30, 33, 0)); exp_q.push_back(mk(3, 31, 33, 1));
    exp_q.push_back(mk(6, 60, 66, 0)); exp_q.push_back(mk(6, 61, 66, 1));
    exp_q.push_back(mk(1, 12, 21, 0)); exp_q.push_back(mk(1, 13, 21, 1));
    obs_cyc.delete();
    drive_inputs();
    drain("rr_drain", 40);
    chk("rr_nbeats", 32'(obs_cyc.size()), 8);
    if (obs_cyc.size() == 8) begin
      chk("rr_throughput", 32'(obs_cyc[1] - obs_cyc[0]), 1);
      chk("rr_bubble", 32'(obs_cyc[2] - obs_cyc[1]), 2);
    end

    // Select mode, channel 2: latency and busy release
    bus.mode = SELECT;
    bus.sel  = 3'd2;
    c0 = cyc;
    push_both(2, 5, 7, 0); push_both(2, 6, 7, 0); push_both(2, 7, 7, 1);
    obs_cyc.delete();
    drive_inputs();
    tick();
    chk("sel_busy_grant", bus.busy, 1);
    chk("sel_in_ready", bus.in_ready, 8'h04);
    tick();
    tick();
    chk("sel_busy_mid", bus.busy, 1);
    tick();
    chk("sel_busy_released", bus.busy, 0);
    drain("sel_drain", 10);
    chk("sel_nbeats", 32'(obs_cyc.size()), 3);
    if (obs_cyc.size() == 3)
      for (int i = 0; i < 3; i++) chk("sel_latency", 32'(obs_cyc[i] - c0), 32'(2 + i));

    // Lock: SEL moves to 4 during a ch3 primitive
    bus.sel = 3'd3;
    push_both(3, 40, 1, 0); push_both(3, 41, 1, 0); push_both(3, 42, 1, 1);
    drive_inputs();
    tick();
    bus.sel = 3'd4;
    push_both(4, 50, 2, 0); push_both(4, 51, 2, 1);
    drive_inputs();
    chk("lock_rdy4", bus.in_ready[4], 0);
    for (int k = 0; k < 10 && n_pend(3) != 0; k++) begin
      tick();
      chk("lock_rdy4", bus.in_ready[4], 0);
    end
    drain("lock_drain", 20);

    // Backpressure mid-primitive on ch5
    bus.sel = 3'd5;
    for (int i = 0; i < 5; i++) push_both(5, 70 + i, 5, i == 4);
    drive_inputs();
    for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
    chk("bp_started", bus.out_valid, 1);
    bus.out_ready = 1'b0;
    ox = bus.out_x;
    oy = bus.out_y;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_x_frozen", bus.out_x, ox);
      chk("bp_y_frozen", bus.out_y, oy);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid_held", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    drain("bp_drain", 20);

    // Highest in-range channel
    bus.sel = 3'd7;
    push_both(7, 90, 9, 0); push_both(7, 91, 9, 1);
    drive_inputs();
    tick();
    chk("sel7_busy", bus.busy, 1);
    chk("sel7_in_ready", bus.in_ready, 8'h80);
    drain("sel7_drain", 10);

    // Round-robin wraps from ch7 to ch0
    bus.mode = RROBIN;
    pend.push_back(mk(7, 2, 2, 1));
    pend.push_back(mk(0, 1, 1, 1));
    exp_q.push_back(mk(0, 1, 1, 1));
    exp_q.push_back(mk(7, 2, 2, 1));
    drive_inputs();
    drain("rr_wrap_drain", 20);

    // Out-of-range SEL on the 6-channel instance
    bus6.mode     = SELECT;
    bus6.sel      = 3'd7;
    bus6.in_valid = 6'h3F;
    bus6.in_last  = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("oor_busy", bus6.busy, 0);
      chk("oor_in_ready", bus6.in_ready, 0);
    end
    bus6.sel = 3'd5;
    tick();
    chk("sel5_nch6_busy", bus6.busy, 1);
    chk("sel5_nch6_in_ready", bus6.in_ready, 6'h20);
    bus6.in_valid = '0;

    // Asynchronous reset mid-primitive
    bus.mode = SELECT;
    bus.sel  = 3'd4;
    for (int i = 0; i < 4; i++) push_both(4, 100 + i, 4, i == 3);
    drive_inputs();
    tick();
    tick();
    chk("pre_rst_valid", bus.out_valid, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_in_ready", bus.in_ready, 0);
    pend.delete();
    exp_q.delete();
    drive_inputs();
    tick();
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    cyc++;
    chk("rst_no_partial_beat", bus.out_valid, 0);
    bus.mode = RROBIN;
    pend.push_back(mk(5, 4, 4, 1));
    pend.push_back(mk(0, 3, 3, 1));
    exp_q.push_back(mk(0, 3, 3, 1));
    exp_q.push_back(mk(5, 4, 4, 1));
    drive_inputs();
    drain("rst_rr_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_draw_coord_arbiter

// File: doc/draw_coord_arbiter.md
DRAW_COORD_ARBITER -- requirements
Module: draw_coord_arbiter

Interface
REQ-001 Parameter NCH, default 8: number of drawing-engine channels (2..16).
REQ-002 Parameter XW, default 9: x-coordinate width.
REQ-003 Parameter YW, default 8: y-coordinate width.
REQ-004 Parameter SW, default $clog2(NCH): channel-index width.
REQ-005 CLK  in  1  single clock; all state on rising edge.
REQ-006 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-007 MODE  in  1  0 = select mode (SEL picks channel), 1 = round-robin mode.
REQ-008 SEL  in  SW  requested channel in select mode.
REQ-009 in_x  in  NCH*XW  packed x per channel; channel i at [i*XW +: XW].
REQ-010 in_y  in  NCH*YW  packed y per channel, same packing.
REQ-011 in_valid  in  NCH  per-channel coordinate beat valid.
REQ-012 in_last  in  NCH  per-channel final beat of current primitive.
REQ-013 in_ready  out  NCH  per-channel beat accepted this cycle (valid & ready).
REQ-014 out_x / out_y  out  XW / YW  registered coordinate to pixel writer.
REQ-015 out_valid  out  1  out_x/out_y/out_last/out_ch hold a beat.
REQ-016 out_last  out  1  beat is last of its primitive.
REQ-017 out_ch  out  SW  source channel of the output beat.
REQ-018 out_ready  in  1  downstream accepts beat when out_valid & out_ready.
REQ-019 busy  out  1  high in LOCK state.

Function
REQ-020 FSM states IDLE, LOCK; grant register gnt (SW bits) valid only in LOCK.
REQ-021 IDLE, MODE=0: if SEL<NCH and in_valid[SEL], next state LOCK, gnt<=SEL; else stay IDLE.
REQ-022 IDLE, MODE=1: grant lowest-numbered valid channel strictly after last-granted index, wrapping NCH-1 -> 0; none valid -> stay IDLE.
REQ-023 MODE and SEL sampled only in IDLE; changes during LOCK ignored until release.
REQ-024 SEL >= NCH in select mode: no grant, all in_ready low.
REQ-025 in_ready[i] = (state==LOCK) & (gnt==i) & (~out_valid | out_ready); all other bits 0.
REQ-026 On accepted beat: out_x/out_y/out_last <= granted channel's inputs, out_ch <= gnt, out_valid <= 1.
REQ-027 out_valid & out_ready with no new accepted beat: out_valid <= 0; data registers hold.
REQ-028 Accepted beat with in_last=1: LOCK -> IDLE on same edge; last-granted index <= gnt.
REQ-029 Latency: request in IDLE at cycle t -> grant edge t+1 -> first beat accepted cycle t+1 -> out_valid at edge t+2.
REQ-030 One idle bubble between primitives (re-arbitration cycle); full throughput (1 beat/cycle) within a primitive while out_ready=1.
REQ-031 Backpressure: out_ready=0 with out_valid=1 holds all outputs stable, in_ready all 0.
REQ-032 Granted channel dropping in_valid mid-primitive: stay LOCK, no beat, no timeout.

Reset
REQ-033 RST_N low: state IDLE, gnt 0, last-granted NCH-1 (so channel 0 wins first RR), out_valid 0, out_x/out_y/out_ch 0, out_last 0, busy 0, in_ready 0 — immediately, no clock needed.
REQ-034 Reset mid-primitive discards held beat and lock; no partial beat emitted after release.

Structure
REQ-035 Package gpu_draw_pkg holds channel index constants (CF=0, CD=1, RF=2, RD=3, LD=4, FU=10, IDLE_CH=15), mode constants SELECT/RROBIN, and FSM state encoding.
REQ-036 Sub-module rr_pick: combinational NCH-wide round-robin picker (req, last index -> found, index); used only in MODE=1.

Verification
REQ-037 Select: MODE=0, SEL=2, ch2 sends (5,7),(6,7),(7,7,last), out_ready=1 -> outputs appear edges t+2..t+4, out_ch=2, out_last only on third, busy drops after third accept.
REQ-038 Round-robin: MODE=1, ch1, ch3, ch6 each valid with 2-beat primitives -> order 1,3,6,1; one bubble between primitives.
REQ-039 Lock: during ch3 primitive, SEL 3->4 and ch4 valid -> ch4 in_ready stays 0 until ch3 last accepted.
REQ-040 Backpressure: out_ready=0 for 3 cycles mid-primitive -> out_x/out_y frozen, in_ready=0, no beat lost or duplicated.
REQ-041 Boundary: NCH=8, SEL=7 valid -> granted; SEL out of range (NCH=6, SEL=7) -> no grant; RR wrap from ch NCH-1 to ch 0.
REQ-042 Reset: assert RST_N low asynchronously mid-primitive -> out_valid, busy, in_ready 0 before next edge; after release ch0 wins RR first.
